// File: rtl/read_pointer_ctrl.sv
// Read-side pointer controller for the async FIFO: Gray/binary read pointer,
// registered empty/almost-empty flags, fill level and sticky underflow.
module read_pointer_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int AEMPTY_RESET = 2
) (
    input  logic                  read_clock,
    input  logic                  read_reset_n,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH:0]   sync_write_ptr,
    input  logic [ADDR_WIDTH:0]   aempty_thresh,
    input  logic                  thresh_load,
    input  logic                  underflow_clear,
    output logic                  read_fire,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic [ADDR_WIDTH:0]   read_ptr,
    output logic                  read_empty,
    output logic                  read_almost_empty,
    output logic [ADDR_WIDTH:0]   read_level,
    output logic                  read_underflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] THRESH_INIT = PW'(AEMPTY_RESET);

    logic [PW-1:0] bin_reg;
    logic [PW-1:0] gray_reg;
    logic [PW-1:0] level_reg;
    logic [PW-1:0] thresh_reg;
    logic          empty_reg;
    logic          aempty_reg;
    logic          underflow_reg;

    logic [PW-1:0] bin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;
    logic          empty_next;
    logic          aempty_next;
    logic          underflow_next;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits from the MSB down to it.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_wdecode
            assign wbin[gi] = ^sync_write_ptr[PW-1:gi];
        end
    endgenerate

    always_comb begin
        read_fire      = read_enable & ~empty_reg;
        bin_next       = bin_reg + {{(PW-1){1'b0}}, read_fire};
        gray_next      = (bin_next >> 1) ^ bin_next;
        level_next     = wbin - bin_next;
        empty_next     = (gray_next == sync_write_ptr);
        aempty_next    = (level_next <= thresh_reg);
        // A new underflow takes priority over a simultaneous clear.
        underflow_next = (read_enable & empty_reg) | (underflow_reg & ~underflow_clear);
    end

    always_ff @(posedge read_clock or negedge read_reset_n) begin
        if (!read_reset_n) begin
            bin_reg       <= '0;
            gray_reg      <= '0;
            level_reg     <= '0;
            thresh_reg    <= THRESH_INIT;
            empty_reg     <= 1'b1;
            aempty_reg    <= 1'b1;
            underflow_reg <= 1'b0;
        end else begin
            bin_reg       <= bin_next;
            gray_reg      <= gray_next;
            level_reg     <= level_next;
            empty_reg     <= empty_next;
            aempty_reg    <= aempty_next;
            underflow_reg <= underflow_next;
            if (thresh_load) begin
                thresh_reg <= aempty_thresh;
            end
        end
    end

    assign read_addr         = bin_reg[ADDR_WIDTH-1:0];
    assign read_ptr          = gray_reg;
    assign read_empty        = empty_reg;
    assign read_almost_empty = aempty_reg;
    assign read_level        = level_reg;
    assign read_underflow    = underflow_reg;

endmodule

// File: tb/tb_read_pointer_ctrl.sv
// Directed bench for read_pointer_ctrl: a behavioural occupancy model pushes
// expected post-edge state into a queue, popped and checked after each edge.
module tb_read_pointer_ctrl;

    localparam int AW = 4;
    localparam int PW = AW + 1;

    logic          read_clock = 1'b0;
    logic          read_reset_n;
    logic          read_enable;
    logic [PW-1:0] sync_write_ptr;
    logic [PW-1:0] aempty_thresh;
    logic          thresh_load;
    logic          underflow_clear;
    logic          read_fire;
    logic [AW-1:0] read_addr;
    logic [PW-1:0] read_ptr;
    logic          read_empty;
    logic          read_almost_empty;
    logic [PW-1:0] read_level;
    logic          read_underflow;

    read_pointer_ctrl #(.ADDR_WIDTH(AW), .AEMPTY_RESET(2)) dut (
        .read_clock        (read_clock),
        .read_reset_n      (read_reset_n),
        .read_enable       (read_enable),
        .sync_write_ptr    (sync_write_ptr),
        .aempty_thresh     (aempty_thresh),
        .thresh_load       (thresh_load),
        .underflow_clear   (underflow_clear),
        .read_fire         (read_fire),
        .read_addr         (read_addr),
        .read_ptr          (read_ptr),
        .read_empty        (read_empty),
        .read_almost_empty (read_almost_empty),
        .read_level        (read_level),
        .read_underflow    (read_underflow)
    );

    always #5 read_clock = ~read_clock;

    typedef struct packed {
        logic [PW-1:0] bin;
        logic [PW-1:0] gray;
        logic [PW-1:0] level;
        logic          empty;
        logic          aempty;
        logic          under;
    } exp_t;

    exp_t exp_q[$];

    int vectors = 0;
    int errors  = 0;

    // Model state: occupancy is derived from a plain binary write count.
    logic [PW-1:0] wcnt;
    logic [PW-1:0] m_bin;
    logic          m_empty;
    logic          m_aempty;
    logic          m_under;
    logic [PW-1:0] m_thresh;

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        wcnt     = '0;
        m_bin    = '0;
        m_empty  = 1'b1;
        m_aempty = 1'b1;
        m_under  = 1'b0;
        m_thresh = PW'(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        $display("reset check %s", tag);
        check({tag, ".empty"},  32'(read_empty), 32'd1);
        check({tag, ".aempty"}, 32'(read_almost_empty), 32'd1);
        check({tag, ".level"},  32'(read_level), 32'd0);
        check({tag, ".ptr"},    32'(read_ptr), 32'd0);
        check({tag, ".addr"},   32'(read_addr), 32'd0);
        check({tag, ".under"},  32'(read_underflow), 32'd0);
        check({tag, ".fire"},   32'(read_fire), 32'd0);
    endtask

    // One read_clock cycle; called just after a rising edge.
    task automatic cycle(input logic re, input logic clr, input logic tload,
                         input logic [PW-1:0] tval, input logic wr);
        exp_t          e;
        logic          fire;
        logic [PW-1:0] lvl;
        if (wr) wcnt = wcnt + 1'b1;
        read_enable     = re;
        underflow_clear = clr;
        thresh_load     = tload;
        aempty_thresh   = tval;
        sync_write_ptr  = to_gray(wcnt);
        #1;
        fire = re & ~m_empty;
        check("fire", 32'(read_fire), 32'(fire));
        m_under  = (re & m_empty) | (m_under & ~clr);
        m_bin    = m_bin + PW'(fire);
        lvl      = wcnt - m_bin;
        m_empty  = (lvl == 0);
        m_aempty = (lvl <= m_thresh);
        if (tload) m_thresh = tval;
        e.bin = m_bin; e.gray = to_gray(m_bin); e.level = lvl;
        e.empty = m_empty; e.aempty = m_aempty; e.under = m_under;
        exp_q.push_back(e);
        @(posedge read_clock);
        #1;
        e = exp_q.pop_front();
        $display("cycle re=%0d clr=%0d ld=%0d wp=%0d | fire=%0d addr=%0d ptr=%0h lvl=%0d emp=%0d ae=%0d uf=%0d",
                 re, clr, tload, wcnt, read_fire, read_addr, read_ptr, read_level,
                 read_empty, read_almost_empty, read_underflow);
        check("addr",   32'(read_addr), 32'(e.bin[AW-1:0]));
        check("ptr",    32'(read_ptr), 32'(e.gray));
        check("level",  32'(read_level), 32'(e.level));
        check("empty",  32'(read_empty), 32'(e.empty));
        check("aempty", 32'(read_almost_empty), 32'(e.aempty));
        check("under",  32'(read_underflow), 32'(e.under));
    endtask

    initial begin
        read_reset_n    = 1'b0;
        read_enable     = 1'b0;
        underflow_clear = 1'b0;
        thresh_load     = 1'b0;
        aempty_thresh   = '0;
        sync_write_ptr  = '0;
        model_reset();
        repeat (3) @(posedge read_clock);
        #1;
        check_reset_outputs("reset");
        read_reset_n = 1'b1;

        // Three writes, no reads.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        // Drain three words, fourth read underflows.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
        // Clear together with a new underflow: set wins; then clear alone.
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
        // Threshold 0 at level 1, then read down to empty.
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, PW'(2), 1'b0);

        // Fill to full and drain, three rounds, wrapping both pointers.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
            check("full.level", 32'(read_level), 32'd16);
            check("full.empty", 32'(read_empty), 32'd0);
            for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
        end
        // Mixed concurrent reads and writes.
        for (int i = 0; i < 24; i++) begin
            logic wr;
            wr = ($urandom_range(0, 1) == 1) && ((wcnt - m_bin) < 16);
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0, wr);
        end

        // Asynchronous reset in mid-operation.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, PW'(7), 1'b0);
        #2;
        read_reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        sync_write_ptr = '0;
        read_enable    = 1'b0;
        thresh_load    = 1'b0;
        @(posedge read_clock);
        #1;
        read_reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
